// File: rtl/phase_measure_if.sv
// Signal bundle between the phase comparator and its GPS/discipline side.
// The 'master' modport is the comparator view; 'slave' is the environment view.
interface phase_measure_if;
  logic        GPS_PPS;
  logic        Coarse_Align;
  logic        Local_PPS;
  logic [23:0] Measure_Phase;
  logic        Measure_Done;
  logic        Pps_Miss;

  modport master (
    input  GPS_PPS,
    input  Coarse_Align,
    output Local_PPS,
    output Measure_Phase,
    output Measure_Done,
    output Pps_Miss
  );

  modport slave (
    output GPS_PPS,
    output Coarse_Align,
    input  Local_PPS,
    input  Measure_Phase,
    input  Measure_Done,
    input  Pps_Miss
  );
endinterface

// File: rtl/phase_measure.sv
// Local 1PPS divider plus signed phase measurement against an asynchronous GPS 1PPS.
// Phase is in CLK_SYS cycles: positive when GPS leads, negative when the local divider leads.
module phase_measure #(
  parameter int unsigned DIV     = 10000000,
  parameter int unsigned PULSE_W = 1000,
  parameter int unsigned WINDOW  = 5000000
) (
  input logic             CLK_SYS,
  input logic             CLK_RST,
  phase_measure_if.master pm
);

  localparam int unsigned      DivW    = $clog2(DIV);
  localparam logic [DivW-1:0]  DivLast = DivW'(DIV - 1);
  localparam logic [DivW-1:0]  PulseW  = DivW'(PULSE_W);
  localparam logic [DivW-1:0]  AlignLd = DivW'(3);
  localparam logic [23:0]      Window  = 24'(WINDOW);

  typedef enum logic [1:0] {StIdle, StWaitLocal, StWaitGps} state_e;

  state_e          state_q, state_d;
  logic            gps_s1_q, gps_s2_q, gps_d_q, gps_evt_q;
  logic [2:0]      loc_pipe_q;
  logic [DivW-1:0] div_cnt_q, div_cnt_d;
  logic            local_pps_q;
  logic [23:0]     pc_q, pc_d;
  logic [23:0]     phase_q, phase_d;
  logic            upd_q, upd_d;
  logic            done_q;
  logic            miss_q, miss_d;
  logic            align;
  logic            wrap;
  logic            gps_evt, loc_evt;

  assign gps_evt = gps_evt_q;
  assign loc_evt = loc_pipe_q[2];
  assign wrap    = (div_cnt_q == DivLast);

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    phase_d = phase_q;
    upd_d   = 1'b0;
    miss_d  = 1'b0;
    align   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (gps_evt && pm.Coarse_Align) begin
          align = 1'b1;
        end else if (gps_evt && loc_evt) begin
          phase_d = '0;
          upd_d   = 1'b1;
        end else if (gps_evt) begin
          pc_d    = 24'd1;
          state_d = StWaitLocal;
        end else if (loc_evt) begin
          pc_d    = 24'd1;
          state_d = StWaitGps;
        end
      end
      // A repeat of the starting source is deliberately not looked at while waiting.
      StWaitLocal: begin
        if (loc_evt) begin
          phase_d = pc_q;
          upd_d   = 1'b1;
          state_d = StIdle;
        end else if (pc_q == Window) begin
          miss_d  = 1'b1;
          state_d = StIdle;
        end else begin
          pc_d = pc_q + 24'd1;
        end
      end
      StWaitGps: begin
        if (gps_evt) begin
          phase_d = 24'd0 - pc_q;
          upd_d   = 1'b1;
          state_d = StIdle;
        end else if (pc_q == Window) begin
          miss_d  = 1'b1;
          state_d = StIdle;
        end else begin
          pc_d = pc_q + 24'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Loading 3 compensates the GPS path latency so the next wraps line up with GPS.
  always_comb begin
    if (align) begin
      div_cnt_d = AlignLd;
    end else if (wrap) begin
      div_cnt_d = '0;
    end else begin
      div_cnt_d = div_cnt_q + DivW'(1);
    end
  end

  always_ff @(posedge CLK_SYS or negedge CLK_RST) begin
    if (!CLK_RST) begin
      gps_s1_q    <= 1'b0;
      gps_s2_q    <= 1'b0;
      gps_d_q     <= 1'b0;
      gps_evt_q   <= 1'b0;
      loc_pipe_q  <= '0;
      div_cnt_q   <= '0;
      local_pps_q <= 1'b0;
      state_q     <= StIdle;
      pc_q        <= '0;
      phase_q     <= '0;
      upd_q       <= 1'b0;
      done_q      <= 1'b0;
      miss_q      <= 1'b0;
    end else begin
      gps_s1_q    <= pm.GPS_PPS;
      gps_s2_q    <= gps_s1_q;
      gps_d_q     <= gps_s2_q;
      gps_evt_q   <= gps_s2_q & ~gps_d_q;
      loc_pipe_q  <= align ? 3'b000 : {loc_pipe_q[1:0], wrap};
      div_cnt_q   <= div_cnt_d;
      local_pps_q <= (div_cnt_d < PulseW);
      state_q     <= state_d;
      pc_q        <= pc_d;
      phase_q     <= phase_d;
      upd_q       <= upd_d;
      done_q      <= upd_q;
      miss_q      <= miss_d;
    end
  end

  assign pm.Local_PPS     = local_pps_q;
  assign pm.Measure_Phase = phase_q;
  assign pm.Measure_Done  = done_q;
  assign pm.Pps_Miss      = miss_q;

endmodule

// File: tb/tb_phase_measure.sv
// Bench for phase_measure: fixed per-second vectors, a mid-measurement reset and random GPS offsets
// scored against a timestamp-level model of first/second edge pairing.
module tb_phase_measure;

  localparam int DIV = 1000;
  localparam int PW  = 100;
  localparam int WIN = 400;

  logic CLK_SYS = 1'b0;
  logic CLK_RST = 1'b1;
  always #5 CLK_SYS = ~CLK_SYS;

  phase_measure_if pm_if ();

  phase_measure #(
    .DIV     (DIV),
    .PULSE_W (PW),
    .WINDOW  (WIN)
  ) dut (
    .CLK_SYS (CLK_SYS),
    .CLK_RST (CLK_RST),
    .pm      (pm_if)
  );

  typedef struct { bit miss; int cyc; int phase; } exp_t;
  typedef struct { int off; bit gps; bit coarse; int done; int miss; int phase; } row_t;

  int          passed;
  int          total;
  int          n;
  exp_t        exp_q[$];
  int          gps_q[$];
  bit          gps_cur;
  bit          gps_prev;
  int          gps_fall;
  // Model state: raw timestamps (cycle the edge is first sampled) of the local wraps and edges.
  int          m_wrap;
  bit          m_wait;
  bit          m_first_gps;
  int          m_t0;
  int          m_align_t;
  int          m_last_phase;
  int          row_done;
  int          row_miss;
  logic [23:0] row_phase;
  row_t        tbl [12];

  task automatic check(input bit ok, input string name, input int act, input int req);
    total++;
    if (ok) passed++;
    else $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, n, act, req);
  endtask

  task automatic model_step();
    bit g, l, c;
    int ph;
    g = gps_cur && !gps_prev;
    l = (n == m_wrap);
    if (l) m_wrap += DIV;
    c = pm_if.Coarse_Align;
    if (m_wait && n > m_t0 + WIN) begin
      exp_q.push_back('{1'b1, m_t0 + WIN + 3, m_last_phase});
      m_wait = 1'b0;
    end
    if (!m_wait) begin
      if (g && c) begin
        m_wrap    = n + DIV;
        m_align_t = n;
      end else if (g && l) begin
        m_last_phase = 0;
        exp_q.push_back('{1'b0, n + 4, 0});
      end else if (g || l) begin
        m_wait      = 1'b1;
        m_first_gps = g;
        m_t0        = n;
      end
    end else if ((m_first_gps && l) || (!m_first_gps && g)) begin
      ph           = m_first_gps ? (n - m_t0) : (m_t0 - n);
      m_last_phase = ph;
      exp_q.push_back('{1'b0, n + 4, ph});
      m_wait       = 1'b0;
    end
  endtask

  task automatic tick();
    exp_t e;
    int   ph;
    bit   exp_pps;
    @(posedge CLK_SYS);
    n++;
    model_step();
    #1;
    ph = int'($signed(pm_if.Measure_Phase));
    if (pm_if.Measure_Done || pm_if.Pps_Miss) begin
      check(!(pm_if.Measure_Done && pm_if.Pps_Miss), "done_miss_exclusive",
            int'(pm_if.Pps_Miss), 0);
      if (pm_if.Measure_Done) begin
        row_done++;
        row_phase = pm_if.Measure_Phase;
      end
      if (pm_if.Pps_Miss) row_miss++;
      if (exp_q.size() == 0) begin
        check(1'b0, "unexpected_event", int'(pm_if.Pps_Miss), -1);
      end else begin
        e = exp_q.pop_front();
        check(e.miss == pm_if.Pps_Miss, "event_kind_miss", int'(pm_if.Pps_Miss), int'(e.miss));
        check(e.cyc == n, "event_cycle", n, e.cyc);
        check(pm_if.Measure_Phase == 24'(e.phase), "measure_phase", ph, e.phase);
      end
    end
    if (exp_q.size() != 0 && exp_q[0].cyc < n) begin
      check(1'b0, "missing_event", -1, exp_q[0].cyc);
      void'(exp_q.pop_front());
    end
    if (n >= m_align_t + 4) begin
      exp_pps = ((n - (m_wrap - DIV)) % DIV) < PW;
      check(pm_if.Local_PPS == exp_pps, "local_pps", int'(pm_if.Local_PPS), int'(exp_pps));
    end
    gps_prev = gps_cur;
    if (gps_q.size() != 0 && gps_q[0] == n + 1) begin
      gps_cur  = 1'b1;
      gps_fall = n + 51;
      void'(gps_q.pop_front());
    end else if (n + 1 == gps_fall) begin
      gps_cur = 1'b0;
    end
    pm_if.GPS_PPS = gps_cur;
  endtask

  task automatic do_reset();
    gps_cur  = 1'b0;
    gps_prev = 1'b0;
    gps_fall = -1;
    gps_q.delete();
    pm_if.GPS_PPS = 1'b0;
    CLK_RST = 1'b0;
    repeat (3) @(posedge CLK_SYS);
    #1;
    check(pm_if.Local_PPS == 1'b0, "rst_local_pps", int'(pm_if.Local_PPS), 0);
    check(pm_if.Measure_Phase == 24'd0, "rst_phase", int'($signed(pm_if.Measure_Phase)), 0);
    check(pm_if.Measure_Done == 1'b0, "rst_done", int'(pm_if.Measure_Done), 0);
    check(pm_if.Pps_Miss == 1'b0, "rst_miss", int'(pm_if.Pps_Miss), 0);
    exp_q.delete();
    n            = 0;
    m_wrap       = DIV;
    m_wait       = 1'b0;
    m_last_phase = 0;
    m_align_t    = -100;
    CLK_RST      = 1'b1;
  endtask

  // One local second centred on the next wrap; GPS (if any) rises at wrap + off.
  task automatic run_second(input int off, input bit gps, input bit coarse);
    int w;
    row_done = 0;
    row_miss = 0;
    w = m_wrap;
    if (gps) gps_q.push_back(w + off);
    pm_if.Coarse_Align = coarse;
    while (n < w + 500) tick();
    pm_if.Coarse_Align = 1'b0;
    check(exp_q.size() == 0, "second_drained", exp_q.size(), 0);
  endtask

  initial begin
    int w;
    tbl[0]  = '{-20,  1'b1, 1'b0, 1, 0,   20};
    tbl[1]  = '{37,   1'b1, 1'b0, 1, 0,  -37};
    tbl[2]  = '{0,    1'b1, 1'b0, 1, 0,    0};
    tbl[3]  = '{1,    1'b1, 1'b0, 1, 0,   -1};
    tbl[4]  = '{0,    1'b0, 1'b0, 0, 1,    0};
    tbl[5]  = '{-1,   1'b1, 1'b0, 1, 0,    1};
    tbl[6]  = '{400,  1'b1, 1'b0, 1, 0, -400};
    tbl[7]  = '{-400, 1'b1, 1'b0, 1, 0,  400};
    tbl[8]  = '{-250, 1'b1, 1'b1, 0, 0,    0};
    tbl[9]  = '{0,    1'b1, 1'b0, 1, 0,    0};
    tbl[10] = '{0,    1'b1, 1'b0, 1, 0,    0};
    tbl[11] = '{-3,   1'b1, 1'b0, 1, 0,    3};

    passed = 0;
    total  = 0;
    pm_if.GPS_PPS      = 1'b0;
    pm_if.Coarse_Align = 1'b0;
    #2;
    do_reset();

    for (int i = 0; i < 12; i++) begin
      run_second(tbl[i].off, tbl[i].gps, tbl[i].coarse);
      check(row_done == tbl[i].done, $sformatf("row%0d_done_count", i), row_done, tbl[i].done);
      check(row_miss == tbl[i].miss, $sformatf("row%0d_miss_count", i), row_miss, tbl[i].miss);
      if (tbl[i].done != 0)
        check(row_phase == 24'(tbl[i].phase), $sformatf("row%0d_phase", i),
              int'($signed(row_phase)), tbl[i].phase);
    end

    // Reset while waiting for GPS with pc at 100, then a clean measurement.
    w = m_wrap;
    while (n < w + 102) tick();
    do_reset();
    run_second(-20, 1'b1, 1'b0);
    check(row_done == 1, "post_reset_done_count", row_done, 1);
    check(row_phase == 24'd20, "post_reset_phase", int'($signed(row_phase)), 20);

    w = m_wrap;
    for (int k = 0; k < 30; k++)
      if ($urandom_range(7) != 0) gps_q.push_back(w + k * DIV + int'($urandom_range(900)) - 450);
    while (n < w + 30 * DIV + 600) tick();
    check(exp_q.size() == 0, "random_drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
